// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: Tuse/Tnew stall detection, E-stage
// forwarding selects, a mult/div busy tracker and a saturating stall counter.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_Rs,
  input  logic [4:0]  D_Rt,
  input  logic [1:0]  D_TuseRs,
  input  logic [1:0]  D_TuseRt,
  input  logic        D_IsMD,
  input  logic [4:0]  E_Rs,
  input  logic [4:0]  E_Rt,
  input  logic [4:0]  E_A3,
  input  logic [4:0]  M_A3,
  input  logic [4:0]  W_A3,
  input  logic        E_RegWrite,
  input  logic        M_RegWrite,
  input  logic        W_RegWrite,
  input  logic [1:0]  E_Tnew,
  input  logic [1:0]  M_Tnew,
  input  logic        E_MDStart,
  input  logic        E_MDIsDiv,
  output logic        F_En,
  output logic        D_En,
  output logic        E_Clr,
  output logic        MD_Busy,
  output logic [1:0]  E_FwdRs,
  output logic [1:0]  E_FwdRt,
  output logic [15:0] StallCnt
);

  localparam logic [3:0]  MD_MULT_LAT   = 4'd5;
  localparam logic [3:0]  MD_DIV_LAT    = 4'd10;
  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  localparam logic [1:0] FWD_NONE = 2'd0;
  localparam logic [1:0] FWD_M    = 2'd1;
  localparam logic [1:0] FWD_W    = 2'd2;

  logic [3:0]  md_cnt_q, md_cnt_d;
  logic        md_busy_q, md_busy_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic e_wr, m_wr, w_wr;
  logic stall_rs, stall_rt, stall_md, stall;
  logic [1:0] fwd_rs, fwd_rt;

  // Register 0 is hardwired, so a write to it never creates a dependency.
  assign e_wr = E_RegWrite && (E_A3 != 5'd0);
  assign m_wr = M_RegWrite && (M_A3 != 5'd0);
  assign w_wr = W_RegWrite && (W_A3 != 5'd0);

  assign stall_rs = (e_wr && (D_Rs == E_A3) && (D_TuseRs < E_Tnew)) ||
                    (m_wr && (D_Rs == M_A3) && (D_TuseRs < M_Tnew));
  assign stall_rt = (e_wr && (D_Rt == E_A3) && (D_TuseRt < E_Tnew)) ||
                    (m_wr && (D_Rt == M_A3) && (D_TuseRt < M_Tnew));
  assign stall_md = D_IsMD && (md_busy_q || E_MDStart);
  assign stall    = stall_rs || stall_rt || stall_md;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    fwd_rs = FWD_NONE;
    fwd_rt = FWD_NONE;
    if (m_wr && (E_Rs == M_A3) && (M_Tnew == 2'd0)) fwd_rs = FWD_M;
    else if (w_wr && (E_Rs == W_A3))                fwd_rs = FWD_W;
    if (m_wr && (E_Rt == M_A3) && (M_Tnew == 2'd0)) fwd_rt = FWD_M;
    else if (w_wr && (E_Rt == W_A3))                fwd_rt = FWD_W;
  end

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_cnt_q != 4'd0)  md_cnt_d = md_cnt_q - 4'd1;
    else if (E_MDStart)    md_cnt_d = E_MDIsDiv ? MD_DIV_LAT : MD_MULT_LAT;
    md_busy_d = (md_cnt_d != 4'd0);

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != STALL_CNT_MAX)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      md_cnt_q    <= 4'd0;
      md_busy_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      md_cnt_q    <= md_cnt_d;
      md_busy_q   <= md_busy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // While reset is low the pipeline flushes: registers enabled, E bubbled, no forwarding.
  assign F_En     = !reset || !stall;
  assign D_En     = !reset || !stall;
  assign E_Clr    = !reset || stall;
  assign E_FwdRs  = reset ? fwd_rs : FWD_NONE;
  assign E_FwdRt  = reset ? fwd_rt : FWD_NONE;
  assign MD_Busy  = md_busy_q;
  assign StallCnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected outputs are queued when
// stimulus is driven and popped at the following negedge.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic        f_en;
    logic        d_en;
    logic        e_clr;
    logic        md_busy;
    logic [1:0]  fwd_rs;
    logic [1:0]  fwd_rt;
    logic [15:0] stall_cnt;
  } outs_t;

  typedef struct {
    string      name;
    logic [4:0] d_rs, d_rt;
    logic [1:0] tuse_rs, tuse_rt;
    logic [4:0] e_a3;
    logic       e_rw;
    logic [1:0] e_tnew;
    logic [4:0] m_a3;
    logic       m_rw;
    logic [1:0] m_tnew;
    logic       stall;
  } stall_row_t;

  typedef struct {
    string      name;
    logic [4:0] e_rs, e_rt, m_a3;
    logic       m_rw;
    logic [1:0] m_tnew;
    logic [4:0] w_a3;
    logic       w_rw;
    logic [1:0] exp_rs, exp_rt;
  } fwd_row_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  D_Rs, D_Rt, E_Rs, E_Rt, E_A3, M_A3, W_A3;
  logic [1:0]  D_TuseRs, D_TuseRt, E_Tnew, M_Tnew;
  logic        D_IsMD, E_RegWrite, M_RegWrite, W_RegWrite, E_MDStart, E_MDIsDiv;
  logic        F_En, D_En, E_Clr, MD_Busy;
  logic [1:0]  E_FwdRs, E_FwdRt;
  logic [15:0] StallCnt;

  int    checks   = 0;
  int    failures = 0;
  int    exp_cnt  = 0;
  outs_t exp_q[$];
  string name_q[$];

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .D_Rs(D_Rs), .D_Rt(D_Rt), .D_TuseRs(D_TuseRs), .D_TuseRt(D_TuseRt), .D_IsMD(D_IsMD),
    .E_Rs(E_Rs), .E_Rt(E_Rt), .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3),
    .E_RegWrite(E_RegWrite), .M_RegWrite(M_RegWrite), .W_RegWrite(W_RegWrite),
    .E_Tnew(E_Tnew), .M_Tnew(M_Tnew), .E_MDStart(E_MDStart), .E_MDIsDiv(E_MDIsDiv),
    .F_En(F_En), .D_En(D_En), .E_Clr(E_Clr), .MD_Busy(MD_Busy),
    .E_FwdRs(E_FwdRs), .E_FwdRt(E_FwdRt), .StallCnt(StallCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic outs_t mk(input logic in_rst, input logic stall, input logic busy,
                               input logic [1:0] frs, input logic [1:0] frt,
                               input int cnt);
    outs_t o;
    o.f_en      = in_rst ? 1'b1 : !stall;
    o.d_en      = in_rst ? 1'b1 : !stall;
    o.e_clr     = in_rst ? 1'b1 : stall;
    o.md_busy   = busy;
    o.fwd_rs    = in_rst ? 2'd0 : frs;
    o.fwd_rt    = in_rst ? 2'd0 : frt;
    o.stall_cnt = 16'(cnt);
    return o;
  endfunction

  function automatic outs_t sample();
    outs_t o;
    o = '{F_En, D_En, E_Clr, MD_Busy, E_FwdRs, E_FwdRt, StallCnt};
    return o;
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("f_en=%b d_en=%b e_clr=%b busy=%b fwd_rs=%0d fwd_rt=%0d cnt=%0d",
                     o.f_en, o.d_en, o.e_clr, o.md_busy, o.fwd_rs, o.fwd_rt, o.stall_cnt);
  endfunction

  task automatic idle_inputs();
    reset = 1'b1;
    D_Rs = 5'd0; D_Rt = 5'd0; D_TuseRs = 2'd3; D_TuseRt = 2'd3; D_IsMD = 1'b0;
    E_Rs = 5'd0; E_Rt = 5'd0; E_A3 = 5'd0; M_A3 = 5'd0; W_A3 = 5'd0;
    E_RegWrite = 1'b0; M_RegWrite = 1'b0; W_RegWrite = 1'b0;
    E_Tnew = 2'd0; M_Tnew = 2'd0; E_MDStart = 1'b0; E_MDIsDiv = 1'b0;
  endtask

  task automatic test_reset();
    outs_t obs, exp;
    string nm;
    idle_inputs();
    reset = 1'b0;
    D_Rs = 5'd8; D_TuseRs = 2'd0; E_A3 = 5'd8; E_RegWrite = 1'b1; E_Tnew = 2'd2;
    E_Rs = 5'd9; M_A3 = 5'd9; M_RegWrite = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) idle_inputs();
      exp_q.push_back(i == 0 ? mk(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 0)
                             : mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 0));
      name_q.push_back(i == 0 ? "reset_forced_outputs" : "reset_release_idle");
      @(negedge clk);
      obs = sample(); exp = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s: got %s expected %s", nm, fmt(obs), fmt(exp));
      end
      @(posedge clk); #1;
    end
    exp_cnt = 0;
  endtask

  task automatic test_stall();
    stall_row_t rows[9];
    outs_t obs, exp;
    string nm;
    rows[0] = '{"lw_use_e",       5'd8, 5'd0, 2'd0, 2'd3, 5'd8, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b1};
    rows[1] = '{"tuse_eq_tnew",   5'd8, 5'd0, 2'd1, 2'd3, 5'd8, 1'b1, 2'd1, 5'd0, 1'b0, 2'd0, 1'b0};
    rows[2] = '{"tuse_lt_tnew",   5'd8, 5'd0, 2'd1, 2'd3, 5'd8, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b1};
    rows[3] = '{"e_not_writing",  5'd8, 5'd0, 2'd0, 2'd3, 5'd8, 1'b0, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0};
    rows[4] = '{"m_stage_rt",     5'd0, 5'd5, 2'd3, 2'd0, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 2'd1, 1'b1};
    rows[5] = '{"m_tnew_zero",    5'd0, 5'd5, 2'd3, 2'd0, 5'd0, 1'b0, 2'd0, 5'd5, 1'b1, 2'd0, 1'b0};
    rows[6] = '{"rs_rt_coincide", 5'd8, 5'd8, 2'd0, 2'd0, 5'd8, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b1};
    rows[7] = '{"reg0_no_stall",  5'd0, 5'd0, 2'd0, 2'd3, 5'd0, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0};
    rows[8] = '{"tuse_unused",    5'd8, 5'd0, 2'd3, 2'd3, 5'd8, 1'b1, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      idle_inputs();
      if (i < 9) begin
        D_Rs = rows[i].d_rs; D_Rt = rows[i].d_rt;
        D_TuseRs = rows[i].tuse_rs; D_TuseRt = rows[i].tuse_rt;
        E_A3 = rows[i].e_a3; E_RegWrite = rows[i].e_rw; E_Tnew = rows[i].e_tnew;
        M_A3 = rows[i].m_a3; M_RegWrite = rows[i].m_rw; M_Tnew = rows[i].m_tnew;
        exp_q.push_back(mk(1'b0, rows[i].stall, 1'b0, 2'd0, 2'd0, exp_cnt));
        name_q.push_back(rows[i].name);
      end else begin
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, exp_cnt));
        name_q.push_back("stall_count_total");
      end
      @(negedge clk);
      obs = sample(); exp = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s: got %s expected %s", nm, fmt(obs), fmt(exp));
      end
      @(posedge clk); #1;
      if (i < 9 && rows[i].stall) exp_cnt++;
    end
  endtask

  task automatic test_forward();
    fwd_row_t rows[6];
    outs_t obs, exp;
    string nm;
    rows[0] = '{"fwd_m_over_w",   5'd9, 5'd0, 5'd9, 1'b1, 2'd0, 5'd9, 1'b1, 2'd1, 2'd0};
    rows[1] = '{"fwd_w_m_nowr",   5'd9, 5'd0, 5'd9, 1'b0, 2'd0, 5'd9, 1'b1, 2'd2, 2'd0};
    rows[2] = '{"fwd_w_m_tnew1",  5'd9, 5'd0, 5'd9, 1'b1, 2'd1, 5'd9, 1'b1, 2'd2, 2'd0};
    rows[3] = '{"fwd_none",       5'd9, 5'd9, 5'd9, 1'b1, 2'd1, 5'd3, 1'b1, 2'd0, 2'd0};
    rows[4] = '{"fwd_split",      5'd7, 5'd4, 5'd4, 1'b1, 2'd0, 5'd7, 1'b1, 2'd2, 2'd1};
    rows[5] = '{"fwd_reg0",       5'd0, 5'd0, 5'd0, 1'b1, 2'd0, 5'd0, 1'b1, 2'd0, 2'd0};
    foreach (rows[i]) begin
      idle_inputs();
      E_Rs = rows[i].e_rs; E_Rt = rows[i].e_rt;
      M_A3 = rows[i].m_a3; M_RegWrite = rows[i].m_rw; M_Tnew = rows[i].m_tnew;
      W_A3 = rows[i].w_a3; W_RegWrite = rows[i].w_rw;
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, rows[i].exp_rs, rows[i].exp_rt, exp_cnt));
      name_q.push_back(rows[i].name);
      @(negedge clk);
      obs = sample(); exp = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s: got %s expected %s", nm, fmt(obs), fmt(exp));
      end
      @(posedge clk); #1;
    end
  endtask

  // Div issued at edge t: busy in cycles 1..10, D_IsMD stalls through cycle 10.
  task automatic test_md_div();
    outs_t obs, exp;
    string nm;
    logic busy, stl;
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      D_IsMD = 1'b1;
      if (i == 0) begin E_MDStart = 1'b1; E_MDIsDiv = 1'b1; end
      busy = (i >= 1) && (i <= 10);
      stl  = (i <= 10);
      exp_q.push_back(mk(1'b0, stl, busy, 2'd0, 2'd0, exp_cnt));
      name_q.push_back($sformatf("div_cycle_%0d", i));
      @(negedge clk);
      obs = sample(); exp = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s: got %s expected %s", nm, fmt(obs), fmt(exp));
      end
      @(posedge clk); #1;
      if (stl) exp_cnt++;
    end
  endtask

  // Mult lasts five cycles; a second start in cycle 2 must not extend it.
  task automatic test_md_mult_restart();
    outs_t obs, exp;
    string nm;
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      E_MDStart = (i == 0) || (i == 2);
      exp_q.push_back(mk(1'b0, 1'b0, (i >= 1) && (i <= 5), 2'd0, 2'd0, exp_cnt));
      name_q.push_back($sformatf("mult_cycle_%0d", i));
      @(negedge clk);
      obs = sample(); exp = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s: got %s expected %s", nm, fmt(obs), fmt(exp));
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset lands on the third busy cycle of a mult and must abort it.
  task automatic test_md_reset_abort();
    outs_t obs, exp;
    string nm;
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      if (i == 0) E_MDStart = 1'b1;
      if (i == 3) reset = 1'b0;
      if (i < 3)       exp_q.push_back(mk(1'b0, 1'b0, i >= 1, 2'd0, 2'd0, exp_cnt));
      else if (i == 3) exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, exp_cnt));
      else             exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 0));
      name_q.push_back($sformatf("mult_abort_cycle_%0d", i));
      @(negedge clk);
      obs = sample(); exp = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s: got %s expected %s", nm, fmt(obs), fmt(exp));
      end
      @(posedge clk); #1;
    end
    exp_cnt = 0;
  endtask

  task automatic test_saturate();
    outs_t obs, exp;
    string nm;
    idle_inputs();
    D_Rs = 5'd8; D_TuseRs = 2'd0; E_A3 = 5'd8; E_RegWrite = 1'b1; E_Tnew = 2'd2;
    repeat (70000) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin idle_inputs(); reset = 1'b0; end
      exp_cnt = (exp_cnt + 70000 > 65535) ? 65535 : exp_cnt + 70000;
      if (i > 0) exp_cnt = 65535;
      exp_q.push_back(i < 2 ? mk(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, exp_cnt)
                            : mk(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, exp_cnt));
      name_q.push_back($sformatf("saturate_%0d", i));
      @(negedge clk);
      obs = sample(); exp = exp_q.pop_front(); nm = name_q.pop_front();
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s: got %s expected %s", nm, fmt(obs), fmt(exp));
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 0));
    name_q.push_back("saturate_then_reset");
    @(negedge clk);
    obs = sample(); exp = exp_q.pop_front(); nm = name_q.pop_front();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %s expected %s", nm, fmt(obs), fmt(exp));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_forward();
    test_md_div();
    test_md_mult_restart();
    test_md_reset_abort();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL expose: clk  in  1  sole clock, all state updates on posedge.
REQ-002 SHALL expose: reset  in  1  synchronous, active-low (0 = reset at next posedge).
REQ-003 SHALL expose: D_Rs, D_Rt  in  5 each  source registers of the D-stage instruction.
REQ-004 SHALL expose: D_TuseRs, D_TuseRt  in  2 each  cycles until D operand is needed; 3 = operand unused.
REQ-005 SHALL expose: D_IsMD  in  1  D instruction accesses the mult/div unit (mult/div/mfhi/mflo/mthi/mtlo).
REQ-006 SHALL expose: E_Rs, E_Rt  in  5 each  source registers of the E-stage instruction.
REQ-007 SHALL expose: E_A3, M_A3, W_A3  in  5 each  destination register per stage.
REQ-008 SHALL expose: E_RegWrite, M_RegWrite, W_RegWrite  in  1 each  stage writes the GPR file.
REQ-009 SHALL expose: E_Tnew, M_Tnew  in  2 each  cycles until the stage result is available (0..2).
REQ-010 SHALL expose: E_MDStart  in  1  E-stage mult/div issues this cycle; E_MDIsDiv  in  1  1 = div, 0 = mult.
REQ-011 SHALL expose: F_En, D_En  out  1 each  F/D pipeline register enables (0 = hold).
REQ-012 SHALL expose: E_Clr  out  1  clear (bubble-insert) of the D->E register.
REQ-013 SHALL expose: MD_Busy  out  1  mult/div unit occupied.
REQ-014 SHALL expose: E_FwdRs, E_FwdRt  out  2 each  E operand source: 0 = GPR/E register, 1 = M result, 2 = W result.
REQ-015 SHALL expose: StallCnt  out  16  saturating count of stall cycles.

Function
REQ-016 SHALL treat any A3 = 0 as non-writing: no stall or forward is ever raised against register 0.
REQ-017 SHALL raise stall_rs when D_Rs = E_A3, E_RegWrite = 1, and D_TuseRs < E_Tnew; or when D_Rs = M_A3, M_RegWrite = 1, and D_TuseRs < M_Tnew; stall_rt is defined identically with D_Rt/D_TuseRt.
REQ-018 SHALL raise stall_md when D_IsMD = 1 and (MD_Busy = 1 or E_MDStart = 1).
REQ-019 SHALL define stall = stall_rs | stall_rt | stall_md, combinational, same cycle.
REQ-020 SHALL drive F_En = D_En = ~stall and E_Clr = stall.
REQ-021 SHALL drive E_FwdRs = 1 if E_Rs = M_A3, M_RegWrite = 1, and M_Tnew = 0; otherwise 2 if E_Rs = W_A3 and W_RegWrite = 1; otherwise 0 (M has priority over W); E_FwdRt is driven identically with E_Rt.
REQ-022 SHALL hold a 4-bit MD counter: on a posedge with E_MDStart = 1 and counter = 0, load 10 if E_MDIsDiv = 1, else 5.
REQ-023 SHALL decrement a nonzero MD counter by 1 per posedge and never wrap below 0.
REQ-024 SHALL ignore E_MDStart while counter != 0 (no reload, no extension).
REQ-025 SHALL drive MD_Busy = (counter != 0), registered, so it is high exactly 5 (mult) or 10 (div) cycles, starting the cycle after the start edge.
REQ-026 SHALL increment StallCnt on each posedge where stall = 1, saturating at 0xFFFF.
REQ-027 SHALL, when multiple stall causes coincide, count one stall cycle per cycle.

Reset
REQ-028 SHALL, on a posedge with reset = 0, clear the MD counter, MD_Busy, and StallCnt to 0, overriding any start or decrement in the same cycle.
REQ-029 SHALL, while reset = 0, force F_En = 1, D_En = 1, E_Clr = 1, and E_FwdRs = E_FwdRt = 0.
REQ-030 SHALL abort an in-flight mult/div on reset: MD_Busy = 0 in the cycle after the reset edge.

Verification
REQ-031 SHALL pass: D lw-use (D_Rs = 8, D_TuseRs = 0, E_A3 = 8, E_RegWrite = 1, E_Tnew = 2) -> F_En = 0, D_En = 0, E_Clr = 1, StallCnt +1.
REQ-032 SHALL pass: E_Rs = 9 with M_A3 = 9, M_Tnew = 0 and W_A3 = 9, both writing -> E_FwdRs = 1; with M_RegWrite = 0 -> E_FwdRs = 2.
REQ-033 SHALL pass: E_MDStart = 1, E_MDIsDiv = 1 at edge t -> MD_Busy high for cycles t+1..t+10; D_IsMD = 1 stalls through t+10 and releases at t+11.
REQ-034 SHALL pass: D_Rs = 0 with E_A3 = 0, E_RegWrite = 1, D_TuseRs = 0, E_Tnew = 2 -> no stall, E_FwdRs = 0.
REQ-035 SHALL pass: mult started, reset = 0 asserted at the 3rd busy cycle -> MD_Busy = 0 and StallCnt = 0 after that edge; a second E_MDStart during busy does not extend MD_Busy.
REQ-036 SHALL pass: stall held for 70000 cycles -> StallCnt = 0xFFFF with no wrap.
